// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU operations, branch conditions
// and processor status values.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU: add, sub (aluB - aluA), and, xor, with ZF/SF/OF
// computed from the result.
module y86_alu
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] aluA,
  input  logic [WIDTH-1:0] aluB,
  input  logic [1:0]       alufun,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int MSB = WIDTH - 1;

  always_comb begin
    result = '0;
    of     = 1'b0;
    case (alufun)
      ALU_ADD: begin
        result = aluB + aluA;
        of     = (aluA[MSB] == aluB[MSB]) && (result[MSB] != aluA[MSB]);
      end
      ALU_SUB: begin
        result = aluB - aluA;
        of     = (aluA[MSB] != aluB[MSB]) && (result[MSB] != aluB[MSB]);
      end
      ALU_AND: result = aluB & aluA;
      default: result = aluB ^ aluA;
    endcase
    zf = (result == '0);
    sf = result[MSB];
  end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 SEQ execute stage: operand selection, ALU, {ZF,SF,OF} register and
// jXX/cmovXX condition. Define EXEC_OUT_REG_EN to register valE and cnd.
module execute_stage
  import y86_pkg::*;
#(
  parameter int         WIDTH  = 64,
  parameter logic [2:0] CC_RST = 3'b100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  input  logic             cc_en,
  output logic [WIDTH-1:0] valE,
  output logic             cnd,
  output logic [2:0]       cc
);

  localparam logic [WIDTH-1:0] STACK_INC = WIDTH'(8);
  localparam logic [WIDTH-1:0] STACK_DEC = {{(WIDTH-4){1'b1}}, 4'b1000};

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_fun;
  logic             use_alu;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zf;
  logic             alu_sf;
  logic             alu_of;
  logic [WIDTH-1:0] vale_comb;
  logic             cnd_comb;
  logic             lt;
  logic [2:0]       cc_d;
  logic [2:0]       cc_q;

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_fun = ALU_ADD;
    use_alu = 1'b1;
    case (icode)
      I_RRMOVQ: alu_a = valA;
      I_IRMOVQ: alu_a = valC;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = valC;
        alu_b = valB;
      end
      I_OPQ: begin
        alu_a   = valA;
        alu_b   = valB;
        alu_fun = ifun[1:0];
        use_alu = (ifun[3:2] == 2'b00);
      end
      I_CALL, I_PUSHQ: begin
        alu_a = STACK_DEC;
        alu_b = valB;
      end
      I_RET, I_POPQ: begin
        alu_a = STACK_INC;
        alu_b = valB;
      end
      default: use_alu = 1'b0;
    endcase
  end

  y86_alu #(.WIDTH(WIDTH)) u_alu (
    .aluA   (alu_a),
    .aluB   (alu_b),
    .alufun (alu_fun),
    .result (alu_result),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  assign vale_comb = use_alu ? alu_result : '0;

  // Condition reads the registered flags, i.e. the state before this cycle's update.
  assign lt = cc_q[1] ^ cc_q[0];

  always_comb begin
    cnd_comb = 1'b0;
    if (icode == I_RRMOVQ || icode == I_JXX) begin
      case (ifun)
        C_YES:   cnd_comb = 1'b1;
        C_LE:    cnd_comb = lt | cc_q[2];
        C_L:     cnd_comb = lt;
        C_E:     cnd_comb = cc_q[2];
        C_NE:    cnd_comb = ~cc_q[2];
        C_GE:    cnd_comb = ~lt;
        C_G:     cnd_comb = ~lt & ~cc_q[2];
        default: cnd_comb = 1'b0;
      endcase
    end
  end

  always_comb begin
    cc_d = cc_q;
    if (cc_en && icode == I_OPQ && ifun[3:2] == 2'b00) begin
      cc_d = {alu_zf, alu_sf, alu_of};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc_q <= CC_RST;
    end else begin
      cc_q <= cc_d;
    end
  end

  assign cc = cc_q;

`ifdef EXEC_OUT_REG_EN
  logic [WIDTH-1:0] vale_d;
  logic [WIDTH-1:0] vale_q;
  logic             cnd_d;
  logic             cnd_q;

  always_comb begin
    vale_d = vale_comb;
    cnd_d  = cnd_comb;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vale_q <= '0;
      cnd_q  <= 1'b0;
    end else begin
      vale_q <= vale_d;
      cnd_q  <= cnd_d;
    end
  end

  assign valE = vale_q;
  assign cnd  = cnd_q;
`else
  assign valE = vale_comb;
  assign cnd  = cnd_comb;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vectors plus randomized
// instructions checked against a behavioural model of the stage.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;
  logic        cc_en;
  logic [63:0] valE;
  logic        cnd;
  logic [2:0]  cc;

  int checks = 0;
  int errors = 0;

  logic [2:0]  m_cc = 3'b000;
  logic [63:0] o_vale, e_vale;
  logic        o_cnd, e_cnd;
  logic [2:0]  o_cc, e_cc;

  always #5 clk = ~clk;

  execute_stage #(.WIDTH(64), .CC_RST(3'b100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .icode (icode),
    .ifun  (ifun),
    .valA  (valA),
    .valB  (valB),
    .valC  (valC),
    .cc_en (cc_en),
    .valE  (valE),
    .cnd   (cnd),
    .cc    (cc)
  );

  // Behavioural model: result by plain arithmetic, overflow from 65-bit signed math.
  task automatic model(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [2:0] ccin, input logic en,
                       output logic [63:0] ve, output logic cd, output logic [2:0] ccout);
    logic [64:0] wide;
    logic        ovf;
    logic        less;
    ve    = '0;
    ccout = ccin;
    ovf   = 1'b0;
    case (ic)
      4'h2: ve = a;
      4'h3: ve = c;
      4'h4, 4'h5: ve = b + c;
      4'h8, 4'hA: ve = b - 64'd8;
      4'h9, 4'hB: ve = b + 64'd8;
      4'h6: begin
        if (fn < 4'd4) begin
          case (fn)
            4'd0: begin
              wide = {a[63], a} + {b[63], b};
              ve   = wide[63:0];
              ovf  = wide[64] != wide[63];
            end
            4'd1: begin
              wide = {b[63], b} - {a[63], a};
              ve   = wide[63:0];
              ovf  = wide[64] != wide[63];
            end
            4'd2:    ve = a & b;
            default: ve = a ^ b;
          endcase
          if (en) ccout = {ve == 64'd0, ve[63], ovf};
        end
      end
      default: ve = '0;
    endcase
    less = ccin[1] ^ ccin[0];
    cd   = 1'b0;
    if (ic == 4'h2 || ic == 4'h7) begin
      case (fn)
        4'd0:    cd = 1'b1;
        4'd1:    cd = less | ccin[2];
        4'd2:    cd = less;
        4'd3:    cd = ccin[2];
        4'd4:    cd = !ccin[2];
        4'd5:    cd = !less;
        4'd6:    cd = !less && !ccin[2];
        default: cd = 1'b0;
      endcase
    end
  endtask

  // Drive one instruction for one cycle; capture outputs and the expected values.
  task automatic step(input logic r, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                      input logic en);
    @(negedge clk);
    rst_n = r;
    icode = ic;
    ifun  = fn;
    valA  = a;
    valB  = b;
    valC  = c;
    cc_en = en;
    model(ic, fn, a, b, c, m_cc, en, e_vale, e_cnd, e_cc);
    if (!r) begin
      e_cc = 3'b100;
`ifdef EXEC_OUT_REG_EN
      e_vale = '0;
      e_cnd  = 1'b0;
`endif
    end
    #1;
`ifndef EXEC_OUT_REG_EN
    o_vale = valE;
    o_cnd  = cnd;
`endif
    @(posedge clk);
    #1;
    o_cc = cc;
`ifdef EXEC_OUT_REG_EN
    o_vale = valE;
    o_cnd  = cnd;
`endif
    m_cc = e_cc;
  endtask

  task automatic test_reset();
    step(1'b0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 1'b1);
    checks++;
    if (o_cc !== 3'b100) begin
      errors++;
      $display("FAIL reset_cc: got %b want %b", o_cc, 3'b100);
    end
    checks++;
    if (o_vale !== 64'd0) begin
      errors++;
      $display("FAIL reset_vale: got %h want 0", o_vale);
    end
    step(1'b1, 4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 1'b1);
    checks++;
    if (o_cnd !== 1'b1) begin
      errors++;
      $display("FAIL reset_je_cnd: got %b want 1", o_cnd);
    end
    checks++;
    if (o_cc !== 3'b100) begin
      errors++;
      $display("FAIL reset_cc_hold: got %b want %b", o_cc, 3'b100);
    end
  endtask

  task automatic test_alu_flags();
    step(1'b1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1);
    checks++;
    if (o_vale !== 64'h8000_0000_0000_0000) begin
      errors++;
      $display("FAIL add_ovf_vale: got %h want %h", o_vale, 64'h8000_0000_0000_0000);
    end
    checks++;
    if (o_cc !== 3'b011) begin
      errors++;
      $display("FAIL add_ovf_cc: got %b want %b", o_cc, 3'b011);
    end
    // le with ZF=0, SF=OF=1 is false
    step(1'b1, 4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 1'b1);
    checks++;
    if (o_cnd !== 1'b0) begin
      errors++;
      $display("FAIL jle_old_cc: got %b want 0", o_cnd);
    end
    step(1'b1, 4'h6, 4'h3, 64'd3, 64'd3, 64'd0, 1'b0);
    checks++;
    if (o_vale !== 64'd0) begin
      errors++;
      $display("FAIL xor_noen_vale: got %h want 0", o_vale);
    end
    checks++;
    if (o_cc !== 3'b011) begin
      errors++;
      $display("FAIL xor_noen_cc: got %b want %b", o_cc, 3'b011);
    end
    step(1'b1, 4'h6, 4'h5, 64'd9, 64'd4, 64'd0, 1'b1);
    checks++;
    if (o_vale !== 64'd0 || o_cc !== 3'b011) begin
      errors++;
      $display("FAIL opq_bad_ifun: got valE=%h cc=%b want valE=0 cc=011", o_vale, o_cc);
    end
    step(1'b1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 1'b1);
    checks++;
    if (o_vale !== 64'd0) begin
      errors++;
      $display("FAIL sub_eq_vale: got %h want 0", o_vale);
    end
    checks++;
    if (o_cc !== 3'b100) begin
      errors++;
      $display("FAIL sub_eq_cc: got %b want %b", o_cc, 3'b100);
    end
    step(1'b1, 4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 1'b1);
    checks++;
    if (o_cnd !== 1'b1) begin
      errors++;
      $display("FAIL jle_new_cc: got %b want 1", o_cnd);
    end
  endtask

  task automatic test_stack_addr();
    step(1'b1, 4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 1'b1);
    checks++;
    if (o_vale !== 64'hF8 || o_cc !== 3'b100) begin
      errors++;
      $display("FAIL pushq: got valE=%h cc=%b want valE=f8 cc=100", o_vale, o_cc);
    end
    step(1'b1, 4'hB, 4'h0, 64'd0, 64'hF8, 64'd0, 1'b1);
    checks++;
    if (o_vale !== 64'h100) begin
      errors++;
      $display("FAIL popq: got %h want 100", o_vale);
    end
    step(1'b1, 4'h4, 4'h0, 64'd0, 64'h200, 64'd8, 1'b1);
    checks++;
    if (o_vale !== 64'h208) begin
      errors++;
      $display("FAIL rmmovq: got %h want 208", o_vale);
    end
    step(1'b1, 4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 1'b1);
    step(1'b1, 4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 1'b1);
    checks++;
    if (o_cnd !== 1'b0) begin
      errors++;
      $display("FAIL jl_zero: got %b want 0", o_cnd);
    end
  endtask

  task automatic test_random();
    logic [3:0]  ic, fn;
    logic [63:0] a, b, c;
    logic        en;
    logic [63:0] pick [5];
    pick[0] = 64'd0;
    pick[1] = 64'd1;
    pick[2] = 64'h7FFF_FFFF_FFFF_FFFF;
    pick[3] = 64'h8000_0000_0000_0000;
    pick[4] = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 300; i++) begin
      ic = 4'($urandom_range(0, 15));
      fn = (ic == 4'h6) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 8));
      c  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: begin a = {$urandom, $urandom}; b = a; end
        1: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
        2: begin a = pick[$urandom_range(0, 4)]; b = pick[$urandom_range(0, 4)]; end
        default: begin a = 64'($urandom_range(0, 7)); b = 64'($urandom_range(0, 7)); end
      endcase
      en = ($urandom_range(0, 4) != 0);
      step(1'b1, ic, fn, a, b, c, en);
      checks++;
      if (o_vale !== e_vale) begin
        errors++;
        $display("FAIL rand_vale[%0d] ic=%h fn=%h: got %h want %h", i, ic, fn, o_vale, e_vale);
      end
      checks++;
      if (o_cnd !== e_cnd) begin
        errors++;
        $display("FAIL rand_cnd[%0d] ic=%h fn=%h: got %b want %b", i, ic, fn, o_cnd, e_cnd);
      end
      checks++;
      if (o_cc !== e_cc) begin
        errors++;
        $display("FAIL rand_cc[%0d] ic=%h fn=%h: got %b want %b", i, ic, fn, o_cc, e_cc);
      end
    end
  endtask

  task automatic test_reset_override();
    step(1'b1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1);
    checks++;
    if (o_cc !== 3'b011) begin
      errors++;
      $display("FAIL pre_reset_cc: got %b want %b", o_cc, 3'b011);
    end
    step(1'b0, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1);
    checks++;
    if (o_cc !== 3'b100) begin
      errors++;
      $display("FAIL reset_wins_cc: got %b want %b", o_cc, 3'b100);
    end
    checks++;
    if (o_vale !== e_vale) begin
      errors++;
      $display("FAIL reset_wins_vale: got %h want %h", o_vale, e_vale);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    icode = 4'h1;
    ifun  = 4'h0;
    valA  = '0;
    valB  = '0;
    valC  = '0;
    cc_en = 1'b0;
    test_reset();
    test_alu_flags();
    test_stack_addr();
    test_random();
    test_reset_override();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
